// File: rtl/filtr_sampler.sv
// filtr_sampler
//   Sample-rate sequencer in front of the adaptive notch filter. A down-counter
//   divides clk into a sample tick. Each accepted tick latches adc_in into
//   data_in and fires a one-cycle sample_trig. The block then waits for
//   filter_done and registers filter_out with a one-cycle out_valid. A tick
//   that lands while a computation is still in flight is dropped and flagged
//   on overrun.
//
//   Optional feature macro: FILTR_SAMPLER_OVR_CNT_EN
//     defined   : 8-bit saturating dropped-tick counter drives ovr_cnt
//     undefined : ovr_cnt is tied to 0; the overrun pulse still works
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-low
//   en           run enable
//   div          sample period minus one (values below 3 act as 3)
//   adc_in       raw input sample
//   data_in      held sample presented to the filter
//   sample_trig  one-cycle start pulse to the filter
//   filter_done  completion strobe from the filter
//   filter_out   filter result
//   out_data     captured filter result
//   out_valid    one-cycle pulse, out_data is new
//   busy         computation in flight (TRIG or BUSY)
//   overrun      one-cycle pulse, a tick was dropped
//   ovr_cnt      saturating dropped-tick count
module filtr_sampler #(
  parameter int DATA_SIZE = 5,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [DATA_SIZE-1:0] adc_in,
  output logic [DATA_SIZE-1:0] data_in,
  output logic                 sample_trig,
  input  logic                 filter_done,
  input  logic [DATA_SIZE-1:0] filter_out,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic [7:0]           ovr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TRIG,
    ST_BUSY
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(3);

  state_t               state_reg, state_next;
  logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 pending_reg, pending_next;
  logic [DATA_SIZE-1:0] data_in_reg, out_data_reg;
  logic                 out_valid_reg, overrun_reg;

  logic [DIV_WIDTH-1:0] eff_div;
  logic                 tick;
  logic                 latch_en;
  logic                 capture_en;
  logic                 drop;

  // Periods shorter than 4 cycles cannot fit TRIG + one filter cycle + WAIT.
  assign eff_div = (div < DIV_MIN) ? DIV_MIN : div;

  // The divider only produces ticks while running; in IDLE it is merely loaded.
  assign tick = (state_reg != ST_IDLE) && en && (cnt_reg == '0);

  // A tick is lost when a computation is in flight and not finishing right now.
  // filter_done during TRIG does not count as finishing.
  assign drop = tick && ((state_reg == ST_TRIG) ||
                         ((state_reg == ST_BUSY) && !filter_done));

  // Divider: load on the first enabled IDLE cycle, then count down and reload
  // on the tick. Holding while en is low freezes it.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == ST_IDLE) begin
      if (en) begin
        cnt_next = eff_div;
      end
    end else if (en) begin
      if (cnt_reg == '0) begin
        cnt_next = eff_div;
      end else begin
        cnt_next = cnt_reg - DIV_WIDTH'(1);
      end
    end
  end

  // Sequencer next-state and datapath strobes.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    latch_en     = 1'b0;
    capture_en   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        pending_next = 1'b0;
        if (en) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (tick || pending_reg) begin
          // A pending tick latches the sample present now, one cycle late.
          latch_en     = 1'b1;
          pending_next = 1'b0;
          state_next   = ST_TRIG;
        end
      end
      ST_TRIG: begin
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (filter_done) begin
          capture_en = 1'b1;
          state_next = en ? ST_WAIT : ST_IDLE;
          // Tick coinciding with completion is kept instead of dropped.
          if (tick) begin
            pending_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (!en) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      pending_reg   <= 1'b0;
      data_in_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pending_reg   <= pending_next;
      out_valid_reg <= capture_en;
      overrun_reg   <= drop;
      if (latch_en) begin
        data_in_reg <= adc_in;
      end
      if (capture_en) begin
        out_data_reg <= filter_out;
      end
    end
  end

`ifdef FILTR_SAMPLER_OVR_CNT_EN
  logic [7:0] ovr_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovr_cnt_reg <= 8'd0;
    end else if (drop && (ovr_cnt_reg != 8'hFF)) begin
      ovr_cnt_reg <= ovr_cnt_reg + 8'd1;
    end
  end

  assign ovr_cnt = ovr_cnt_reg;
`else
  assign ovr_cnt = 8'd0;
`endif

  assign data_in     = data_in_reg;
  assign out_data    = out_data_reg;
  assign out_valid   = out_valid_reg;
  assign overrun     = overrun_reg;
  assign sample_trig = (state_reg == ST_TRIG);
  assign busy        = (state_reg == ST_TRIG) || (state_reg == ST_BUSY);

endmodule
